// File: rtl/memory_read_responder_pkg.sv
// Shared types and limits for the memory read responder.
package memory_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam int MAX_READ_LATENCY = 4;
  // Wide enough for READ_LATENCY-1 at the maximum latency.
  localparam int LAT_CNT_W        = 2;

endpackage

// File: rtl/memory_read_responder_if.sv
// Read request / response / snoop-broadcast bundle between requester and responder.
interface memory_read_if #(
  parameter int AW = 11,
  parameter int DW = 16
);
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  logic [DW-1:0] req_data;
  logic          broadcast_valid;
  logic [AW-1:0] broadcast_addr;

  modport master (
    output req_valid, req_addr,
    input  req_ready, req_data, broadcast_valid, broadcast_addr
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, req_data, broadcast_valid, broadcast_addr
  );
endinterface

// File: rtl/memory_read_responder_bram.sv
// Single-port RAM with write enable and a LAT-stage registered read pipeline.
module bram_sp_lat #(
  parameter int DW  = 16,
  parameter int AW  = 11,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0]          mem_q [2**AW];
  logic [LAT-1:0][DW-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Stage 0 holds the read word; later stages just delay it.
  always_ff @(posedge clk) begin
    if (re_i) pipe_q[0] <= mem_q[addr_i];
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign rdata_o = pipe_q[LAT-1];

endmodule

// File: rtl/memory_read_responder.sv
// Memory-side responder: fixed-latency reads with snoop broadcast, host write port.
module memory_read_responder
  import memory_responder_pkg::*;
#(
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int READ_LATENCY      = 1,   // legal 1..MAX_READ_LATENCY
  parameter int COUNT_WIDTH       = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  memory_read_if.slave                 req_if,
  input  logic                         wr_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0] wr_addr,
  input  logic [MEMORY_WIDTH-1:0]      wr_data,
  output logic                         wr_ready,
  output logic [COUNT_WIDTH-1:0]       reads_served
);

  localparam int AW = MEMORY_ADDR_WIDTH;
  localparam int DW = MEMORY_WIDTH;

  state_e                 state_q, state_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [DW-1:0]          hold_q;
  logic [COUNT_WIDTH-1:0] served_q;
  logic                   we, accept, resp;
  logic [DW-1:0]          rdata;

  bram_sp_lat #(.DW(DW), .AW(AW), .LAT(READ_LATENCY)) u_bram (
    .clk     (clk),
    .we_i    (we),
    .re_i    (accept),
    .addr_i  (we ? wr_addr : req_if.req_addr),
    .wdata_i (wr_data),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we       = 1'b0;
    accept   = 1'b0;
    wr_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // Host write wins; the requester keeps its read pending.
        if (wr_valid) begin
          we       = 1'b1;
          wr_ready = 1'b1;
        end else if (req_if.req_valid) begin
          accept  = 1'b1;
          addr_d  = req_if.req_addr;
          cnt_d   = LAT_CNT_W'(READ_LATENCY - 1);
          state_d = (READ_LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign resp = (state_q == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      hold_q   <= '0;
      served_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (resp) begin
        hold_q <= rdata;
        if (served_q != '1) served_q <= served_q + 1'b1;
      end
    end
  end

  // Data is live from the RAM pipe in RESP and held from the last response otherwise.
  assign req_if.req_ready       = resp;
  assign req_if.req_data        = resp ? rdata : hold_q;
  assign req_if.broadcast_valid = resp;
  assign req_if.broadcast_addr  = addr_q;
  assign reads_served           = served_q;

endmodule

// File: tb/tb_memory_read_responder.sv
// Randomized bench: one responder per READ_LATENCY 1..4, each against a timestamp-based model.
module tb_memory_read_responder;
  localparam int AW   = 11;
  localparam int DW   = 16;
  localparam int CW   = 4;
  localparam int NL   = 4;
  localparam int NCYC = 800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int L = g + 1;

    logic          rst;
    logic          wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [CW-1:0] reads_served;

    memory_read_if #(.AW(AW), .DW(DW)) bus ();

    memory_read_responder #(
      .MEMORY_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW), .READ_LATENCY(L), .COUNT_WIDTH(CW)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_if       (bus),
      .wr_valid     (wr_valid),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .reads_served (reads_served)
    );

    initial begin : stim
      logic [DW-1:0] ref_mem [int];
      logic [AW-1:0] tab [16];
      logic [3:0]    idx;
      logic [DW-1:0] exp_data, last_data;
      logic [AW-1:0] exp_addr;
      int            due, cnt;
      bit            idle, ready, drop_rd, drop_wr;
      string         p;

      p = $sformatf("L%0d", L);
      tab[0] = 11'h005;
      tab[1] = 11'h010;
      for (int i = 2; i < 16; i++) tab[i] = AW'(i * 131);

      rst = 1'b1;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      bus.req_valid = 1'b0; bus.req_addr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk({p, " rst_ready"}, 32'(bus.req_ready), 32'd0);
      chk({p, " rst_bvalid"}, 32'(bus.broadcast_valid), 32'd0);
      chk({p, " rst_baddr"}, 32'(bus.broadcast_addr), 32'd0);
      chk({p, " rst_data"}, 32'(bus.req_data), 32'd0);
      chk({p, " rst_count"}, 32'(reads_served), 32'd0);

      due = -1; cnt = 0; last_data = '0; exp_data = '0; exp_addr = '0;
      drop_rd = 1'b0; drop_wr = 1'b0;

      for (int c = 0; c < NCYC; c++) begin
        // drive this cycle's inputs
        rst = 1'b0;
        if (drop_rd) begin bus.req_valid = 1'b0; drop_rd = 1'b0; end
        if (drop_wr) begin wr_valid = 1'b0; drop_wr = 1'b0; end
        if (c < 16) begin
          wr_valid = 1'b1;
          wr_addr  = tab[c];
          wr_data  = (c == 0) ? 16'hBEEF : DW'($urandom);
        end else begin
          if (!wr_valid && $urandom_range(0, 5) == 0) begin
            idx = 4'($urandom_range(0, 15));
            wr_valid = 1'b1; wr_addr = tab[idx]; wr_data = DW'($urandom);
          end
          if (!bus.req_valid && $urandom_range(0, 2) == 0) begin
            idx = 4'($urandom_range(0, 15));
            bus.req_valid = 1'b1; bus.req_addr = tab[idx];
          end else if (due > c && $urandom_range(0, 7) == 0) begin
            idx = 4'($urandom_range(0, 15));
            bus.req_addr = tab[idx];
          end else if (due > c && $urandom_range(0, 19) == 0) begin
            bus.req_valid = 1'b0;
          end
          if (!wr_valid && $urandom_range(0, 149) == 0) rst = 1'b1;
        end
        #1;

        // expected outputs for this cycle
        idle  = (due < c);
        ready = (due == c);
        chk({p, " ready"}, 32'(bus.req_ready), 32'(ready));
        chk({p, " bvalid"}, 32'(bus.broadcast_valid), 32'(ready));
        chk({p, " data"}, 32'(bus.req_data), 32'(ready ? exp_data : last_data));
        if (ready) chk({p, " baddr"}, 32'(bus.broadcast_addr), 32'(exp_addr));
        chk({p, " wr_ready"}, 32'(wr_ready), 32'(idle && wr_valid));
        chk({p, " count"}, 32'(reads_served), 32'(cnt));

        // effect of the coming edge
        if (rst) begin
          due = -1; cnt = 0; last_data = '0;
        end else begin
          if (ready) begin
            last_data = exp_data;
            if (cnt < (1 << CW) - 1) cnt++;
            drop_rd = 1'b1;
          end
          if (idle && wr_valid) begin
            ref_mem[int'(wr_addr)] = wr_data;
            drop_wr = 1'b1;
          end else if (idle && bus.req_valid) begin
            due      = c + L;
            exp_data = ref_mem[int'(bus.req_addr)];
            exp_addr = bus.req_addr;
          end
        end
        @(negedge clk);
      end
      done_cnt++;
    end
  end

  initial begin
    repeat (NCYC + 40) @(posedge clk);
    chk("lanes_done", 32'(done_cnt), 32'(NL));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
